// File: rtl/tpu_pkg.sv
// Shared definitions for the NxN matrix-multiply engine.
//   - command opcodes carried on cmd[2:0]
//   - FSM state encoding
//   - clog2 helper and the systolic skew depth (3N-2 MAC cycles)
package tpu_pkg;

    localparam logic [2:0] OP_CLEAR    = 3'd0;
    localparam logic [2:0] OP_LOAD_A   = 3'd1;
    localparam logic [2:0] OP_LOAD_B   = 3'd2;
    localparam logic [2:0] OP_RUN      = 3'd3;
    localparam logic [2:0] OP_RUN_ACC  = 3'd4;
    localparam logic [2:0] OP_READ     = 3'd5;
    localparam logic [2:0] OP_READ_SAT = 3'd6;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_LOAD    = 2'd1;
    localparam logic [1:0] ST_COMPUTE = 2'd2;
    localparam logic [1:0] ST_READ    = 2'd3;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Cycles from first injection until the far corner PE has seen its last operand pair.
    function automatic int skew_depth(input int n);
        return 3 * n - 2;
    endfunction

endpackage

// File: rtl/mac_pe.sv
// One systolic array cell.
//   clk, rst_n   clock / async active-low reset
//   clr_i        zero the accumulator (wins over acc_en_i)
//   acc_en_i     add a_i*b_i into the accumulator
//   a_i, b_i     operands from the left / from above
//   a_o, b_o     registered pass-through to the right / below
//   acc_o        accumulator value
module mac_pe #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16,
    parameter int SIGNED = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              acc_en_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] a_o,
    output logic [DATA_W-1:0] b_o,
    output logic [ACC_W-1:0]  acc_o
);

    localparam int PW = 2 * DATA_W + 2;

    logic [DATA_W-1:0] a_q, b_q;
    logic [ACC_W-1:0]  acc_q, acc_d;

    // One extra bit lets a single signed multiplier cover both modes:
    // the top bit is the operand sign when SIGNED, else a zero.
    logic signed [DATA_W:0] a_x, b_x;
    logic signed [PW-1:0]   prod;

    assign a_x  = {(SIGNED != 0) & a_i[DATA_W-1], a_i};
    assign b_x  = {(SIGNED != 0) & b_i[DATA_W-1], b_i};
    assign prod = a_x * b_x;

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (acc_en_i) begin
            acc_d = acc_q + ACC_W'(prod);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else begin
            a_q   <= a_i;
            b_q   <= b_i;
            acc_q <= acc_d;
        end
    end

    assign a_o   = a_q;
    assign b_o   = b_q;
    assign acc_o = acc_q;

endmodule

// File: rtl/mmu_seq_nxn.sv
// NxN matrix-multiply engine: byte-serial operand load, skewed systolic
// compute over an NxN mac_pe array, and a backpressured byte readout.
//   clk, rst_n             clock / async active-low reset
//   cmd_valid, cmd         command strobe and opcode (see tpu_pkg)
//   cmd_ready, busy        ready only in IDLE; busy = ~cmd_ready
//   in_valid, in_data      operand stream, row-major, used only in LOAD
//   done                   one-cycle pulse at the end of RUN / RUN_ACC
//   out_valid, out_ready   result stream handshake
//   out_data, out_last     result byte, last-byte marker
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_IDLE    | waiting for a command; CLEAR handled in place
// ST_LOAD    | writing N*N operand elements into A or B
// ST_COMPUTE | injecting skewed operands, t = 0..3N-2
// ST_READ    | serialising C (raw bytes or saturated bytes)
module mmu_seq_nxn
    import tpu_pkg::*;
#(
    parameter int N      = 2,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16,
    parameter int SIGNED = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    input  logic [2:0]        cmd,
    output logic              cmd_ready,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              busy,
    output logic              done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic              out_last
);

    localparam int NN   = N * N;
    localparam int IW   = clog2(NN);
    localparam int SKEW = skew_depth(N);
    localparam int CW   = clog2(SKEW + 1);
    localparam int BPE  = ACC_W / 8;
    localparam int BW   = (BPE > 1) ? clog2(BPE) : 1;

    localparam logic [ACC_W-1:0] S_MAX = ACC_W'(127);
    localparam logic [ACC_W-1:0] S_MIN = ACC_W'(-128);
    localparam logic [ACC_W-1:0] U_MAX = ACC_W'(255);

    logic [1:0]        state_q, state_d;
    logic [IW-1:0]     cnt_q, cnt_d;
    logic              sel_b_q, sel_b_d;
    logic [CW-1:0]     t_q, t_d;
    logic [IW-1:0]     elem_q, elem_d;
    logic [BW-1:0]     byte_q, byte_d;
    logic              sat_q, sat_d;
    logic              out_valid_q, out_valid_d;
    logic              done_q, done_d;
    logic              acc_clr, acc_en, wr_a, wr_b;
    logic              last_byte;

    logic [DATA_W-1:0] a_buf_q [NN];
    logic [DATA_W-1:0] b_buf_q [NN];
    logic [DATA_W-1:0] a_inj   [N];
    logic [DATA_W-1:0] b_inj   [N];
    logic [ACC_W-1:0]  acc_w   [NN];

    logic [ACC_W-1:0]  acc_sel, acc_shift;
    logic [7:0]        raw_byte, sat_byte;

    assign acc_en    = (state_q == ST_COMPUTE);
    assign last_byte = sat_q || (byte_q == BW'(BPE - 1));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sel_b_d     = sel_b_q;
        t_d         = t_q;
        elem_d      = elem_q;
        byte_d      = byte_q;
        sat_d       = sat_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;
        acc_clr     = 1'b0;
        wr_a        = 1'b0;
        wr_b        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (cmd)
                        OP_CLEAR: acc_clr = 1'b1;
                        OP_LOAD_A, OP_LOAD_B: begin
                            state_d = ST_LOAD;
                            sel_b_d = (cmd == OP_LOAD_B);
                            cnt_d   = '0;
                        end
                        OP_RUN, OP_RUN_ACC: begin
                            acc_clr = (cmd == OP_RUN);
                            state_d = ST_COMPUTE;
                            t_d     = '0;
                        end
                        OP_READ, OP_READ_SAT: begin
                            state_d     = ST_READ;
                            sat_d       = (cmd == OP_READ_SAT);
                            elem_d      = '0;
                            byte_d      = '0;
                            out_valid_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            ST_LOAD: begin
                if (in_valid) begin
                    wr_a = ~sel_b_q;
                    wr_b = sel_b_q;
                    if (cnt_q == IW'(NN - 1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_COMPUTE: begin
                if (t_q == CW'(SKEW)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    t_d = t_q + 1'b1;
                end
            end
            default: begin
                if (out_valid_q && out_ready) begin
                    if (out_last) begin
                        out_valid_d = 1'b0;
                        state_d     = ST_IDLE;
                    end else if (last_byte) begin
                        byte_d = '0;
                        elem_d = elem_q + 1'b1;
                    end else begin
                        byte_d = byte_q + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            sel_b_q     <= 1'b0;
            t_q         <= '0;
            elem_q      <= '0;
            byte_q      <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            for (int k = 0; k < NN; k++) begin
                a_buf_q[k] <= '0;
                b_buf_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_b_q     <= sel_b_d;
            t_q         <= t_d;
            elem_q      <= elem_d;
            byte_q      <= byte_d;
            sat_q       <= sat_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            if (wr_a) a_buf_q[cnt_q] <= in_data;
            if (wr_b) b_buf_q[cnt_q] <= in_data;
        end
    end

    // Edge injection at step t: row i of A carries A[i][t-i], column j of B
    // carries B[t-j][j]; outside 0..N-1 (and outside COMPUTE) zeros are fed,
    // so the pass-through registers hold zeros whenever a run starts.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_inj[i] = '0;
            b_inj[i] = '0;
            if (acc_en && (t_q >= CW'(i)) && (t_q < CW'(i + N))) begin
                a_inj[i] = a_buf_q[IW'(IW'(i * N) + IW'(t_q - CW'(i)))];
                b_inj[i] = b_buf_q[IW'(IW'(t_q - CW'(i)) * IW'(N) + IW'(i))];
            end
        end
    end

    logic [DATA_W-1:0] a_h [N][N+1];
    logic [DATA_W-1:0] b_v [N+1][N];
    logic [N-1:0]      unused_a_edge, unused_b_edge;

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        assign a_h[gi][0]       = a_inj[gi];
        assign b_v[0][gi]       = b_inj[gi];
        assign unused_a_edge[gi] = ^a_h[gi][N];
        assign unused_b_edge[gi] = ^b_v[N][gi];
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            mac_pe #(
                .DATA_W (DATA_W),
                .ACC_W  (ACC_W),
                .SIGNED (SIGNED)
            ) u_pe (
                .clk      (clk),
                .rst_n    (rst_n),
                .clr_i    (acc_clr),
                .acc_en_i (acc_en),
                .a_i      (a_h[gi][gj]),
                .b_i      (b_v[gi][gj]),
                .a_o      (a_h[gi][gj+1]),
                .b_o      (b_v[gi+1][gj]),
                .acc_o    (acc_w[gi*N+gj])
            );
        end
    end

    always_comb begin
        acc_sel   = acc_w[elem_q];
        acc_shift = acc_sel >> (8 * byte_q);
        raw_byte  = acc_shift[7:0];
        if (SIGNED != 0) begin
            if ($signed(acc_sel) > $signed(S_MAX)) begin
                sat_byte = 8'h7F;
            end else if ($signed(acc_sel) < $signed(S_MIN)) begin
                sat_byte = 8'h80;
            end else begin
                sat_byte = acc_sel[7:0];
            end
        end else begin
            sat_byte = (acc_sel > U_MAX) ? 8'hFF : acc_sel[7:0];
        end
    end

    // Outputs derive from held indices, so they stay stable through a stall.
    assign out_valid = out_valid_q;
    assign out_data  = out_valid_q ? (sat_q ? sat_byte : raw_byte) : 8'h00;
    assign out_last  = out_valid_q && (elem_q == IW'(NN - 1)) && last_byte;
    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = ~cmd_ready;
    assign done      = done_q;

endmodule
